// File: rtl/cla_sub_seq.sv
// cla_sub_seq - sequential multi-slice subtractor.
//
// Computes diff = (a - b) mod 2^WIDTH one 5-bit slice per cycle. The slice
// uses borrow lookahead internally. The borrow is carried between slices in
// a register, so a single 5-bit lookahead slice serves any multiple-of-5 width.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   request operands present
//   in_ready   block can accept a request (IDLE and not in reset)
//   a, b       minuend / subtrahend, sampled only on accept
//   out_valid  result valid (DONE)
//   out_ready  consumer takes the result
//   diff       (a - b) mod 2^WIDTH
//   borrow     final borrow, 1 iff a < b unsigned
//   zero       1 iff diff == 0
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; in_ready high
// RUN   | one slice per cycle, slice k = bits [5k+4:5k]
// DONE  | result held stable on diff/borrow/zero until out_ready

module cla_sub_seq #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);

    localparam int NSLICE = WIDTH / 5;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] K_LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    k_q, k_d;
    logic             bin_q, bin_d;
    logic             borrow_q, borrow_d;
    logic             zero_q, zero_d;
    logic             out_valid_q, out_valid_d;

    logic             accept;
    logic [4:0]       sa, sb, g, p, d;
    logic [5:0]       c;

    // in_ready is gated by rst so that a request presented during reset is
    // never accepted, even though the state register already reads IDLE.
    assign in_ready = (state_q == IDLE) & ~rst;
    assign accept   = in_valid & in_ready;

    // 5-bit borrow-lookahead slice. The operand registers are shifted down
    // by one slice per RUN cycle, so the current slice always sits in [4:0].
    always_comb begin
        sa   = a_q[4:0];
        sb   = b_q[4:0];
        g    = ~sa & sb;
        p    = ~(sa ^ sb);
        c[0] = bin_q;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        c[5] = g[4] | (p[4] & g[3]) | (p[4] & p[3] & g[2])
             | (p[4] & p[3] & p[2] & g[1])
             | (p[4] & p[3] & p[2] & p[1] & g[0])
             | (p[4] & p[3] & p[2] & p[1] & p[0] & c[0]);
        d    = sa ^ sb ^ c[4:0];
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        diff_d      = diff_q;
        k_d         = k_q;
        bin_d       = bin_q;
        borrow_d    = borrow_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d      = a;
                    b_d      = b;
                    diff_d   = '0;
                    k_d      = '0;
                    bin_d    = 1'b0;
                    borrow_d = 1'b0;
                    zero_d   = 1'b0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                for (int s = 0; s < NSLICE; s++) begin
                    if (k_q == CW'(s)) begin
                        diff_d[5*s +: 5] = d;
                    end
                end
                a_d   = a_q >> 5;
                b_d   = b_q >> 5;
                bin_d = c[5];
                if (k_q == K_LAST) begin
                    borrow_d    = c[5];
                    zero_d      = (diff_d == '0);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            k_q         <= '0;
            bin_q       <= 1'b0;
            borrow_q    <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            diff_q      <= diff_d;
            k_q         <= k_d;
            bin_q       <= bin_d;
            borrow_q    <= borrow_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign zero      = zero_q;

endmodule
